snoop_cache_node: RTL and testbench

SNOOP_CACHE_NODE -- requirements
Module: snoop_cache_node

---
 rtl/snoop_pkg.sv | 25 ++
 rtl/cache_line_array.sv | 59 +++++
 rtl/snoop_cache_node.sv | 212 +++++++++++++++++++++
 tb/tb_snoop_cache_node.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/snoop_pkg.sv
// Shared encodings for the snooping MSI cache node: line states, bus commands, controller states.
package snoop_pkg;

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_t;

    localparam logic [1:0] CMD_WB    = 2'b00;
    localparam logic [1:0] CMD_RMISS = 2'b01;
    localparam logic [1:0] CMD_WMISS = 2'b10;
    localparam logic [1:0] CMD_INV   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_VICTIM,
        MISS_REQ,
        WAIT_FILL,
        INV_REQ,
        FINISH
    } state_t;

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: two combinational read ports, one local write port and
// one snoop state-update port; the snoop update wins when both target the same line.
module cache_line_array
    import snoop_pkg::*;
#(
    parameter  int ADDR_W = 3,
    parameter  int DATA_W = 4,
    parameter  int LINES  = 2,
    localparam int IDX_W  = $clog2(LINES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  lk_idx,
    output logic [1:0]        lk_state,
    output logic [ADDR_W-1:0] lk_tag,
    output logic [DATA_W-1:0] lk_data,
    input  logic [IDX_W-1:0]  sn_idx,
    output logic [1:0]        sn_state,
    output logic [ADDR_W-1:0] sn_tag,
    output logic [DATA_W-1:0] sn_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [1:0]        wr_state,
    input  logic [ADDR_W-1:0] wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              sn_upd,
    input  logic [1:0]        sn_upd_state
);

    logic [1:0]        st_q  [LINES];
    logic [ADDR_W-1:0] tag_q [LINES];
    logic [DATA_W-1:0] dat_q [LINES];

    assign lk_state = st_q[lk_idx];
    assign lk_tag   = tag_q[lk_idx];
    assign lk_data  = dat_q[lk_idx];
    assign sn_state = st_q[sn_idx];
    assign sn_tag   = tag_q[sn_idx];
    assign sn_data  = dat_q[sn_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                st_q[i]  <= MSI_I;
                tag_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            if (wr_en && !(sn_upd && sn_idx == wr_idx)) begin
                st_q[wr_idx]  <= wr_state;
                tag_q[wr_idx] <= wr_tag;
                dat_q[wr_idx] <= wr_data;
            end
            if (sn_upd)
                st_q[sn_idx] <= sn_upd_state;
        end
    end

endmodule

// File: rtl/snoop_cache_node.sv
// One node of a snooping MSI cache: serves local read/write requests over a shared bus
// and reacts to other nodes' bus traffic in every controller state.
module snoop_cache_node
    import snoop_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    parameter int LINES  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              execute_instruction,
    input  logic              instruction,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              bus_out_valid,
    output logic [1:0]        bus_out_cmd,
    output logic [ADDR_W-1:0] bus_out_addr,
    output logic [DATA_W-1:0] bus_out_data,
    input  logic              bus_in_valid,
    input  logic [1:0]        bus_in_cmd,
    input  logic [ADDR_W-1:0] bus_in_addr,
    input  logic [DATA_W-1:0] bus_in_data,
    input  logic              bus_in_reply,
    output logic              snoop_wb,
    output logic [ADDR_W-1:0] snoop_wb_addr,
    output logic [DATA_W-1:0] snoop_wb_data
);

    localparam int IDX_W = $clog2(LINES);

    state_t state, state_n;

    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic [IDX_W-1:0]  idx, sn_idx;
    logic [1:0]        lk_state, sn_state;
    logic [ADDR_W-1:0] lk_tag, sn_tag;
    logic [DATA_W-1:0] lk_data, sn_data;

    logic              wr_en;
    logic [1:0]        wr_state;
    logic [ADDR_W-1:0] wr_tag;
    logic [DATA_W-1:0] wr_data;

    logic              snoop_act, sn_hit, sn_upd, sn_wb, lk_hit, lk_stall;
    logic [1:0]        sn_new;

    assign idx    = req_addr[IDX_W-1:0];
    assign sn_idx = bus_in_addr[IDX_W-1:0];

    cache_line_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) u_lines (
        .clock       (clock),
        .reset       (reset),
        .lk_idx      (idx),
        .lk_state    (lk_state),
        .lk_tag      (lk_tag),
        .lk_data     (lk_data),
        .sn_idx      (sn_idx),
        .sn_state    (sn_state),
        .sn_tag      (sn_tag),
        .sn_data     (sn_data),
        .wr_en       (wr_en),
        .wr_idx      (idx),
        .wr_state    (wr_state),
        .wr_tag      (wr_tag),
        .wr_data     (wr_data),
        .sn_upd      (sn_upd),
        .sn_upd_state(sn_new)
    );

    // Fill replies are not snooped; they only complete our own outstanding read miss.
    assign snoop_act = bus_in_valid && !bus_in_reply;
    assign sn_hit    = snoop_act && sn_state != MSI_I && sn_tag == bus_in_addr;
    assign lk_hit    = lk_state != MSI_I && lk_tag == req_addr;
    assign lk_stall  = snoop_act && sn_idx == idx;

    always_comb begin
        sn_upd = 1'b0;
        sn_new = MSI_I;
        sn_wb  = 1'b0;
        if (sn_hit) begin
            case (bus_in_cmd)
                CMD_RMISS: if (sn_state == MSI_M) begin
                    sn_upd = 1'b1; sn_new = MSI_S; sn_wb = 1'b1;
                end
                CMD_WMISS: begin
                    sn_upd = 1'b1;
                    sn_wb  = (sn_state == MSI_M);
                end
                CMD_INV: sn_upd = (sn_state == MSI_S);
                default: ;
            endcase
        end
    end

    // A miss invalidates the victim at lookup time, so no snoop can touch this index
    // again until our own fill or write-miss lands there.
    always_comb begin
        state_n  = state;
        wr_en    = 1'b0;
        wr_state = MSI_I;
        wr_tag   = req_addr;
        wr_data  = req_data;
        case (state)
            IDLE:      if (execute_instruction && done) state_n = LOOKUP;
            LOOKUP: if (!lk_stall) begin
                if (lk_hit) begin
                    if (!req_wr)
                        state_n = FINISH;
                    else if (lk_state == MSI_M) begin
                        wr_en = 1'b1; wr_state = MSI_M; state_n = FINISH;
                    end else
                        state_n = INV_REQ;
                end else begin
                    wr_en   = 1'b1;
                    wr_tag  = lk_tag;
                    wr_data = lk_data;
                    state_n = (lk_state == MSI_M) ? WB_VICTIM : MISS_REQ;
                end
            end
            WB_VICTIM: state_n = MISS_REQ;
            MISS_REQ: begin
                if (req_wr) begin
                    wr_en = 1'b1; wr_state = MSI_M; state_n = FINISH;
                end else
                    state_n = WAIT_FILL;
            end
            WAIT_FILL: if (bus_in_reply && bus_in_addr == req_addr) begin
                wr_en = 1'b1; wr_state = MSI_S; wr_data = bus_in_data; state_n = FINISH;
            end
            INV_REQ: begin
                if (sn_upd && sn_idx == idx)
                    state_n = MISS_REQ;
                else begin
                    wr_en = 1'b1; wr_state = MSI_M; state_n = FINISH;
                end
            end
            FINISH:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            done          <= 1'b1;
            data_out      <= '0;
            req_wr        <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
            bus_out_valid <= 1'b0;
            bus_out_cmd   <= '0;
            bus_out_addr  <= '0;
            bus_out_data  <= '0;
            snoop_wb      <= 1'b0;
            snoop_wb_addr <= '0;
            snoop_wb_data <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == LOOKUP) begin
                req_wr   <= instruction;
                req_addr <= address;
                req_data <= data_in;
                done     <= 1'b0;
            end
            if (state == FINISH)
                done <= 1'b1;
            if (state_n == FINISH && state != FINISH)
                data_out <= (state == WAIT_FILL) ? bus_in_data : (req_wr ? req_data : lk_data);

            // Bus messages are one-cycle pulses raised on entry to an emitting state.
            bus_out_valid <= 1'b0;
            bus_out_cmd   <= '0;
            bus_out_addr  <= '0;
            bus_out_data  <= '0;
            if (state_n != state) begin
                case (state_n)
                    WB_VICTIM: begin
                        bus_out_valid <= 1'b1;
                        bus_out_cmd   <= CMD_WB;
                        bus_out_addr  <= lk_tag;
                        bus_out_data  <= lk_data;
                    end
                    MISS_REQ: begin
                        bus_out_valid <= 1'b1;
                        bus_out_cmd   <= req_wr ? CMD_WMISS : CMD_RMISS;
                        bus_out_addr  <= req_addr;
                        bus_out_data  <= req_wr ? req_data : '0;
                    end
                    INV_REQ: begin
                        bus_out_valid <= 1'b1;
                        bus_out_cmd   <= CMD_INV;
                        bus_out_addr  <= req_addr;
                    end
                    default: ;
                endcase
            end

            snoop_wb <= sn_wb;
            if (sn_wb) begin
                snoop_wb_addr <= sn_tag;
                snoop_wb_data <= sn_data;
            end
        end
    end

endmodule

// File: tb/tb_snoop_cache_node.sv
// Directed bench for snoop_cache_node (LINES=2, ADDR_W=3, DATA_W=4): fills, hits,
// upgrades, victim write-back, snoop stall, snoop invalidate during upgrade, reset.
module tb_snoop_cache_node;

    logic       clock = 1'b0;
    logic       reset;
    logic       execute_instruction, instruction;
    logic [2:0] address;
    logic [3:0] data_in, data_out;
    logic       done;
    logic       bus_out_valid;
    logic [1:0] bus_out_cmd;
    logic [2:0] bus_out_addr;
    logic [3:0] bus_out_data;
    logic       bus_in_valid, bus_in_reply;
    logic [1:0] bus_in_cmd;
    logic [2:0] bus_in_addr;
    logic [3:0] bus_in_data;
    logic       snoop_wb;
    logic [2:0] snoop_wb_addr;
    logic [3:0] snoop_wb_data;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    snoop_cache_node #(.ADDR_W(3), .DATA_W(4), .LINES(2)) dut (
        .clock(clock), .reset(reset),
        .execute_instruction(execute_instruction), .instruction(instruction),
        .address(address), .data_in(data_in), .data_out(data_out), .done(done),
        .bus_out_valid(bus_out_valid), .bus_out_cmd(bus_out_cmd),
        .bus_out_addr(bus_out_addr), .bus_out_data(bus_out_data),
        .bus_in_valid(bus_in_valid), .bus_in_cmd(bus_in_cmd),
        .bus_in_addr(bus_in_addr), .bus_in_data(bus_in_data), .bus_in_reply(bus_in_reply),
        .snoop_wb(snoop_wb), .snoop_wb_addr(snoop_wb_addr), .snoop_wb_data(snoop_wb_data)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [2:0] a, input logic [3:0] d);
        execute_instruction = 1'b1;
        instruction = wr;
        address = a;
        data_in = d;
        step();
        execute_instruction = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        execute_instruction = 1'b0; instruction = 1'b0; address = '0; data_in = '0;
        bus_in_valid = 1'b0; bus_in_cmd = '0; bus_in_addr = '0; bus_in_data = '0;
        bus_in_reply = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_done", done, 1);
        chk("rst_data_out", data_out, 0);
        chk("rst_bus_valid", bus_out_valid, 0);
        chk("rst_snoop_wb", snoop_wb, 0);
        chk("rst_l1_state", dut.u_lines.st_q[1], 0);

        // Read miss on addr 3, wrong-address reply ignored, then fill with A.
        issue(1'b0, 3'd3, 4'h0);
        chk("rd3_busy", done, 0);
        step();
        chk("rd3_rmiss_valid", bus_out_valid, 1);
        chk("rd3_rmiss_cmd", bus_out_cmd, 2'b01);
        chk("rd3_rmiss_addr", bus_out_addr, 3);
        step();
        chk("rd3_rmiss_1cyc", bus_out_valid, 0);
        bus_in_reply = 1'b1; bus_in_addr = 3'd1; bus_in_data = 4'hF;
        step();
        chk("rd3_wrong_reply_busy", done, 0);
        bus_in_addr = 3'd3; bus_in_data = 4'hA;
        step();
        bus_in_reply = 1'b0;
        chk("rd3_fill_data", data_out, 4'hA);
        step();
        chk("rd3_done", done, 1);
        chk("rd3_l1_state_S", dut.u_lines.st_q[1], 2'b01);

        // Read hit: done exactly two edges after acceptance, no bus traffic.
        issue(1'b0, 3'd3, 4'h0);
        step();
        chk("hit_no_bus", bus_out_valid, 0);
        chk("hit_not_done_1edge", done, 0);
        step();
        chk("hit_done_2edges", done, 1);
        chk("hit_data", data_out, 4'hA);

        // Write 5 to addr 3 on S: invalidate then M.
        issue(1'b1, 3'd3, 4'h5);
        step();
        chk("up_inv_valid", bus_out_valid, 1);
        chk("up_inv_cmd", bus_out_cmd, 2'b11);
        chk("up_inv_addr", bus_out_addr, 3);
        step();
        chk("up_inv_1cyc", bus_out_valid, 0);
        chk("up_data", data_out, 4'h5);
        step();
        chk("up_done", done, 1);
        chk("up_l1_state_M", dut.u_lines.st_q[1], 2'b10);

        // Write 7 to addr 1: victim addr 3 (M) written back, then write_miss.
        issue(1'b1, 3'd1, 4'h7);
        step();
        chk("wb_valid", bus_out_valid, 1);
        chk("wb_cmd", bus_out_cmd, 2'b00);
        chk("wb_addr", bus_out_addr, 3);
        chk("wb_data", bus_out_data, 4'h5);
        step();
        chk("wm_valid", bus_out_valid, 1);
        chk("wm_cmd", bus_out_cmd, 2'b10);
        chk("wm_addr", bus_out_addr, 1);
        step();
        chk("wm_bus_clear", bus_out_valid, 0);
        chk("wm_data_out", data_out, 4'h7);
        step();
        chk("wm_done", done, 1);
        chk("wm_l1_state_M", dut.u_lines.st_q[1], 2'b10);
        chk("wm_l1_tag", dut.u_lines.tag_q[1], 1);
        chk("wm_l1_data", dut.u_lines.dat_q[1], 4'h7);

        // Snoop read_miss addr 1 coincident with our lookup of addr 1: stall one cycle.
        issue(1'b0, 3'd1, 4'h0);
        bus_in_valid = 1'b1; bus_in_cmd = 2'b01; bus_in_addr = 3'd1;
        step();
        bus_in_valid = 1'b0;
        chk("sn_wb", snoop_wb, 1);
        chk("sn_wb_addr", snoop_wb_addr, 1);
        chk("sn_wb_data", snoop_wb_data, 4'h7);
        chk("sn_l1_state_S", dut.u_lines.st_q[1], 2'b01);
        step();
        chk("sn_wb_1cyc", snoop_wb, 0);
        chk("sn_stall_not_done", done, 0);
        chk("sn_read_data", data_out, 4'h7);
        step();
        chk("sn_done", done, 1);

        // Write 3 to addr 1 on S; another node invalidates during our upgrade.
        issue(1'b1, 3'd1, 4'h3);
        step();
        chk("inv_race_inv_cmd", bus_out_cmd, 2'b11);
        bus_in_valid = 1'b1; bus_in_cmd = 2'b11; bus_in_addr = 3'd1;
        step();
        bus_in_valid = 1'b0;
        chk("inv_race_wm_valid", bus_out_valid, 1);
        chk("inv_race_wm_cmd", bus_out_cmd, 2'b10);
        chk("inv_race_l1_I", dut.u_lines.st_q[1], 2'b00);
        step();
        chk("inv_race_data", data_out, 4'h3);
        step();
        chk("inv_race_done", done, 1);
        chk("inv_race_l1_M", dut.u_lines.st_q[1], 2'b10);

        // Reset while waiting for a fill; the late reply must be ignored.
        issue(1'b0, 3'd2, 4'h0);
        step();
        chk("rst_mid_rmiss_addr", bus_out_addr, 2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_done", done, 1);
        chk("rst_mid_bus", bus_out_valid, 0);
        chk("rst_mid_data_out", data_out, 0);
        chk("rst_mid_l1_I", dut.u_lines.st_q[1], 0);
        bus_in_reply = 1'b1; bus_in_addr = 3'd2; bus_in_data = 4'h9;
        step();
        bus_in_reply = 1'b0;
        chk("late_reply_data_out", data_out, 0);
        chk("late_reply_l0_I", dut.u_lines.st_q[0], 0);
        chk("late_reply_done", done, 1);
        chk("late_reply_bus", bus_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
